// File: rtl/pc_gen.sv
// Fetch-stage PC generator: issues word-aligned fetches, registers fetched words to decode,
// handles stalls via a 1-entry skid buffer and EX redirects. Macro PC_GEN_BP_EN enables branch prediction.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        bp_taken,
    input  logic [31:0] bp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_pred_taken
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drain_tgt_q, drain_tgt_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic            if_pred_q, if_pred_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic            skid_pred_q, skid_pred_d;
    logic [XLEN-1:0] skid_npc_q, skid_npc_d;

    logic            req_c;
    logic            accept_c;
    logic            fetch_live_c;
    logic            taken_c;
    logic [XLEN-1:0] npc_c;
    logic [XLEN-1:0] ex_tgt_c;

    assign ex_tgt_c = ex_target & ALIGN_MASK;

    // Next sequential/predicted PC for the address currently on imem_addr
    always_comb begin
        taken_c = 1'b0;
        npc_c   = pc_q + XLEN'(4);
`ifdef PC_GEN_BP_EN
        if (bp_taken) begin
            taken_c = 1'b1;
            npc_c   = bp_target & ALIGN_MASK;
        end
`endif
    end

`ifndef PC_GEN_BP_EN
    logic unused_bp_c;
    assign unused_bp_c = ^{bp_taken, bp_target};
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // An issued-but-unaccepted request must stay on the bus; redirects wait it out in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (req_c && !imem_ready) state_d = ex_redirect ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_ready)       state_d = ST_FETCH;
                else if (ex_redirect) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (imem_ready) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        req_c = 1'b0;
        if (!rst) begin
            if (state_q == ST_FETCH) req_c = !stall && !skid_valid_q;
            else                     req_c = 1'b1;
        end
        accept_c     = req_c && imem_ready;
        fetch_live_c = accept_c && (state_q != ST_DRAIN) && !ex_redirect;
    end

    // Datapath: redirect > drain completion > stall capture > skid replay > normal delivery
    always_comb begin
        pc_d         = pc_q;
        drain_tgt_d  = drain_tgt_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_pred_d    = if_pred_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pred_d  = skid_pred_q;
        skid_npc_d   = skid_npc_q;
        if (ex_redirect) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            drain_tgt_d  = ex_tgt_c;
            if (state_d != ST_DRAIN) pc_d = ex_tgt_c;
        end else if (state_q == ST_DRAIN) begin
            if (imem_ready) pc_d = drain_tgt_q;
        end else if (stall) begin
            if (fetch_live_c) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pred_d  = taken_c;
                skid_npc_d   = npc_c;
            end
        end else if (skid_valid_q) begin
            if_valid_d   = 1'b1;
            if_pc_d      = pc_q;
            if_instr_d   = skid_instr_q;
            if_pred_d    = skid_pred_q;
            pc_d         = skid_npc_q;
            skid_valid_d = 1'b0;
        end else if (fetch_live_c) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            if_pred_d  = taken_c;
            pc_d       = npc_c;
        end else begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drain_tgt_q  <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            if_pred_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pred_q  <= 1'b0;
            skid_npc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            drain_tgt_q  <= drain_tgt_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_pred_q    <= if_pred_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pred_q  <= skid_pred_d;
            skid_npc_q   <= skid_npc_d;
        end
    end

    assign imem_req      = req_c;
    assign imem_addr     = pc_q;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;
    assign if_pred_taken = if_pred_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: stall  input  1  hazard hold; freezes PC and if_* outputs.
REQ-005 SHALL have port: ex_redirect  input  1  misprediction resolved in EX; flush and refetch.
REQ-006 SHALL have port: ex_target  input  32  correct PC on ex_redirect.
REQ-007 SHALL have port: bp_taken  input  1  prediction for imem_addr, from the branch prediction unit.
REQ-008 SHALL have port: bp_target  input  32  predicted target for imem_addr.
REQ-009 SHALL have port: imem_req  output  1  instruction memory request valid.
REQ-010 SHALL have port: imem_addr  output  32  word-aligned fetch address.
REQ-011 SHALL have port: imem_ready  input  1  request accepted and data valid this cycle.
REQ-012 SHALL have port: imem_rdata  input  32  instruction word, valid with imem_ready.
REQ-013 SHALL have port: if_valid  output  1  if_pc/if_instr hold a live instruction for decode.
REQ-014 SHALL have port: if_pc  output  32  PC of delivered instruction.
REQ-015 SHALL have port: if_instr  output  32  delivered instruction word.
REQ-016 SHALL have port: if_pred_taken  output  1  prediction applied to the delivered instruction.

Function
REQ-017 SHALL implement states FETCH (request issued), WAIT (request outstanding, imem_ready low), DRAIN (outstanding request is wrong-path).
REQ-018 SHALL drive imem_addr = pc register; imem_req = 1 in WAIT/DRAIN, and 1 in FETCH only when stall=0 and skid buffer empty.
REQ-019 SHALL hold imem_addr stable while imem_req=1 and imem_ready=0; FETCH->WAIT on req&!ready.
REQ-020 SHALL, on req&ready in FETCH/WAIT, register {pc, imem_rdata, taken} to if_* with if_valid=1 next cycle (1-cycle latency from ready), and update pc.
REQ-021 SHALL compute next pc = bp_target if taken else pc+4, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
REQ-022 SHALL force bits [1:0] of every loaded target (bp_target, ex_target) to 0.
REQ-023 SHALL, with stall=1, hold pc, if_valid, if_pc, if_instr, if_pred_taken unchanged.
REQ-024 SHALL capture a response that completes during stall into a 1-entry skid buffer; delivered to if_* on first cycle stall=0.
REQ-025 SHALL, on ex_redirect, load pc=ex_target, clear if_valid and skid buffer, regardless of stall (redirect overrides stall).
REQ-026 SHALL, on ex_redirect while in WAIT, go to DRAIN: keep request stable, discard returned data, then FETCH from ex_target.
REQ-027 SHALL apply priority rst > ex_redirect > stall > bp_taken > pc+4.
REQ-028 SHALL, if ex_redirect arrives in the same cycle as imem_ready, discard that response and fetch ex_target next.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0, if_instr=0, if_pred_taken=0, skid buffer empty.
REQ-030 SHALL drop any outstanding request on reset mid-WAIT/DRAIN; imem_req=0 in the cycle after reset is applied while rst stays high.
REQ-031 SHALL issue first request for RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-032 SHALL use macro PC_GEN_BP_EN: when defined, bp_taken/bp_target steer next pc per REQ-021.
REQ-033 SHALL, without PC_GEN_BP_EN, ignore bp_taken/bp_target (static not-taken), next pc always pc+4, if_pred_taken tied 0.

Verification
REQ-034 SHALL cover reset release, imem_ready always 1 -> imem_addr 0xBFC00000, 0xBFC00004, 0xBFC00008; if_valid 1 cycle after each ready.
REQ-035 SHALL cover imem_ready low 3 cycles at 0xBFC00004 -> imem_addr held 3 cycles, if_pc=0xBFC00004 delivered once.
REQ-036 SHALL cover bp_taken=1, bp_target=0x80000102 at pc 0xBFC00008 (PC_GEN_BP_EN) -> next imem_addr 0x80000100, if_pred_taken=1.
REQ-037 SHALL cover ex_redirect, ex_target=0x00400000 during WAIT -> returned word discarded, if_valid=0, next delivered if_pc=0x00400000.
REQ-038 SHALL cover stall=1 for 4 cycles with response arriving in cycle 1 -> if_* frozen, buffered word delivered on stall release, no loss or duplication.
REQ-039 SHALL cover pc=0xFFFFFFFC sequential fetch -> next imem_addr 0x00000000.
